// File: rtl/fir_dac_tx.sv
// fir_dac_tx: serializes one filtered sample per frame into a 16-bit
// MCP49x1-style SPI write frame (mode 0, MSB first), then strobes LDAC.
// Optional build macro: FIR_DAC_SIGNED_EN -- when defined, sample_in is two's
// complement and is converted to offset binary before framing; when undefined,
// sample_in is unsigned and passes through unchanged.
module fir_dac_tx #(
  parameter int          WIDTH   = 10,
  parameter int          CLK_DIV = 4,
  parameter logic [3:0]  CONFIG  = 4'b0111
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             dac_cs_n,
  output logic             dac_sclk,
  output logic             dac_mosi,
  output logic             dac_ldac_n,
  output logic             busy
);

  localparam int              DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_LDAC  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [3:0]       r_bit, w_bit_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_cs_n, w_cs_n_nxt;
  logic             r_mosi, w_mosi_nxt;
  logic             r_ldac_n, w_ldac_n_nxt;
  logic             r_ready, w_ready_nxt;
  logic [15:0]      r_shift, w_shift_nxt;

  logic             w_accept;
  logic             w_div_end;
  logic [15:0]      w_frame;

  // Left-justify the sample into the 12-bit DAC data field; in the signed
  // build the MSB flip turns two's complement into offset binary so that the
  // most negative input lands on code 0 and zero lands on mid-scale.
  function automatic logic [11:0] frame_payload(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    v = s;
`ifdef FIR_DAC_SIGNED_EN
    v[WIDTH-1] = ~s[WIDTH-1];
`endif
    return 12'(v) << (12 - WIDTH);
  endfunction

  assign w_accept  = r_ready & sample_valid;
  assign w_div_end = (r_div == DIV_LAST);
  assign w_frame   = {CONFIG, frame_payload(sample_in)};

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bit_nxt    = r_bit;
    w_sclk_nxt   = r_sclk;
    w_cs_n_nxt   = r_cs_n;
    w_mosi_nxt   = r_mosi;
    w_ldac_n_nxt = r_ldac_n;
    w_ready_nxt  = r_ready;
    w_shift_nxt  = r_shift;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_cs_n_nxt  = 1'b0;
          w_ready_nxt = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_bit_nxt   = 4'd0;
          w_mosi_nxt  = w_frame[15];
          w_shift_nxt = {w_frame[14:0], 1'b0};
        end
      end
      S_SHIFT: begin
        if (w_div_end) begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_bit == 4'd15) begin
              // Last high phase done: drop the frame and deselect the DAC.
              w_state_nxt = S_GAP;
              w_cs_n_nxt  = 1'b1;
              w_bit_nxt   = 4'd0;
              w_mosi_nxt  = 1'b0;
            end else begin
              // Falling edge: present the next bit for the next rising edge.
              w_bit_nxt   = r_bit + 4'd1;
              w_mosi_nxt  = r_shift[15];
              w_shift_nxt = {r_shift[14:0], 1'b0};
            end
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_GAP: begin
        if (w_div_end) begin
          w_div_nxt    = '0;
          w_state_nxt  = S_LDAC;
          w_ldac_n_nxt = 1'b0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_LDAC: begin
        if (w_div_end) begin
          w_div_nxt    = '0;
          w_state_nxt  = S_IDLE;
          w_ldac_n_nxt = 1'b1;
          w_ready_nxt  = 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_div_nxt    = '0;
        w_bit_nxt    = 4'd0;
        w_sclk_nxt   = 1'b0;
        w_cs_n_nxt   = 1'b1;
        w_mosi_nxt   = 1'b0;
        w_ldac_n_nxt = 1'b1;
        w_ready_nxt  = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any frame in progress immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control counters and pin-driving flops (outputs come straight from here)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_bit    <= 4'd0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_mosi   <= 1'b0;
      r_ldac_n <= 1'b1;
      r_ready  <= 1'b1;
    end else begin
      r_div    <= w_div_nxt;
      r_bit    <= w_bit_nxt;
      r_sclk   <= w_sclk_nxt;
      r_cs_n   <= w_cs_n_nxt;
      r_mosi   <= w_mosi_nxt;
      r_ldac_n <= w_ldac_n_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  // Frame shift register: pure data, reloaded on every acceptance
  always_ff @(posedge clock) begin
    r_shift <= w_shift_nxt;
  end

  assign sample_ready = r_ready;
  assign dac_cs_n     = r_cs_n;
  assign dac_sclk     = r_sclk;
  assign dac_mosi     = r_mosi;
  assign dac_ldac_n   = r_ldac_n;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_dac_tx.sv
// Directed bench for fir_dac_tx (CLK_DIV=4, WIDTH=10). Expected frames follow
// the build: FIR_DAC_SIGNED_EN selects the offset-binary table.
module tb_fir_dac_tx;

  localparam int CD = 4;
  localparam int W  = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n, busy;

  fir_dac_tx #(.WIDTH(W), .CLK_DIV(CD), .CONFIG(4'b0111)) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .dac_cs_n    (dac_cs_n),
    .dac_sclk    (dac_sclk),
    .dac_mosi    (dac_mosi),
    .dac_ldac_n  (dac_ldac_n),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // SPI receiver model: samples the pins on the falling system clock edge.
  logic [15:0] fr_q[$];
  int          fb_q[$];
  logic [15:0] mon_cap = '0;
  int          mon_bits = 0;
  logic        p_cs = 1'b1;
  logic        p_sclk = 1'b0;

  always @(negedge clock) begin
    if (p_cs && !dac_cs_n) begin
      mon_cap  = '0;
      mon_bits = 0;
    end else if (!dac_cs_n && !p_sclk && dac_sclk) begin
      mon_cap  = {mon_cap[14:0], dac_mosi};
      mon_bits = mon_bits + 1;
    end
    if (!p_cs && dac_cs_n) begin
      fr_q.push_back(mon_cap);
      fb_q.push_back(mon_bits);
    end
    p_cs   = dac_cs_n;
    p_sclk = dac_sclk;
  end

  // Acceptance log: cycle number of each valid&&ready edge
  int cyc = 0;
  int acc_t[$];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (sample_valid && sample_ready && !reset) acc_t.push_back(cyc);
  end

  typedef struct {
    logic [W-1:0] smp;
    logic [15:0]  frm;
    string        nm;
  } vec_t;

  vec_t vt[4];
  logic [15:0] e200, e201;

  // One frame with one-cycle valid; optionally pokes valid mid-SHIFT.
  task automatic run_frame(input logic [W-1:0] s, input logic [15:0] exp,
                           input string nm, input bit inj);
    int base, abase, n, rl, cl, ll, gl, bl;
    base = fr_q.size();
    abase = acc_t.size();
    rl = 0; cl = 0; ll = 0; gl = 0; bl = 0; n = 0;
    @(negedge clock);
    sample_in = s;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    while (sample_ready == 1'b0 && n < 1000) begin
      if (!dac_cs_n) cl++;
      if (!dac_ldac_n) ll++;
      if (dac_cs_n && dac_ldac_n) gl++;
      if (busy) bl++;
      rl++;
      if (inj && n == 20) begin
        sample_in = 10'd5;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    sample_valid = 1'b0;
    chk({nm, "_ready_low"}, rl, 34 * CD);
    chk({nm, "_busy_high"}, bl, 34 * CD);
    chk({nm, "_cs_low"},    cl, 32 * CD);
    chk({nm, "_gap"},       gl, CD);
    chk({nm, "_ldac_low"},  ll, CD);
    repeat (150) @(negedge clock);
    chk({nm, "_accepts"},   acc_t.size() - abase, 1);
    chk({nm, "_nframes"},   fr_q.size() - base, 1);
    if (fr_q.size() > base) begin
      chk({nm, "_frame"}, fr_q[base], exp);
      chk({nm, "_bits"},  fb_q[base], 16);
    end
  endtask

  initial begin
    int base, abase, n;
`ifdef FIR_DAC_SIGNED_EN
    vt[0] = '{10'h3FF, 16'h77FC, "s_m1"};
    vt[1] = '{10'h200, 16'h7000, "s_min"};
    vt[2] = '{10'h000, 16'h7800, "s_zero"};
    vt[3] = '{10'h0C8, 16'h7B20, "s_200"};
    e200 = 16'h7B20;
    e201 = 16'h7B24;
`else
    vt[0] = '{10'd200, 16'h7320, "u_200"};
    vt[1] = '{10'd0,   16'h7000, "u_zero"};
    vt[2] = '{10'h3FF, 16'h7FFC, "u_max"};
    vt[3] = '{10'h155, 16'h7554, "u_155"};
    e200 = 16'h7320;
    e201 = 16'h7324;
`endif

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ready", sample_ready, 1);
    chk("rst_cs_n",  dac_cs_n, 1);
    chk("rst_sclk",  dac_sclk, 0);
    chk("rst_mosi",  dac_mosi, 0);
    chk("rst_ldac",  dac_ldac_n, 1);
    chk("rst_busy",  busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) run_frame(vt[i].smp, vt[i].frm, vt[i].nm, 1'b0);

    // Back-to-back with valid held high; sample_in changes during frame 1
    base = fr_q.size();
    abase = acc_t.size();
    @(negedge clock);
    sample_in = 10'd200;
    sample_valid = 1'b1;
    n = 0;
    while (acc_t.size() <= abase && n < 20) begin @(negedge clock); n++; end
    sample_in = 10'd201;
    n = 0;
    while (acc_t.size() <= abase + 1 && n < 400) begin @(negedge clock); n++; end
    sample_valid = 1'b0;
    n = 0;
    while (sample_ready == 1'b0 && n < 400) begin @(negedge clock); n++; end
    repeat (4) @(negedge clock);
    chk("b2b_accepts", acc_t.size() - abase, 2);
    chk("b2b_nframes", fr_q.size() - base, 2);
    if (acc_t.size() >= abase + 2) chk("b2b_spacing", acc_t[abase+1] - acc_t[abase], 34 * CD + 1);
    if (fr_q.size() >= base + 2) begin
      chk("b2b_frame1", fr_q[base], e200);
      chk("b2b_frame2", fr_q[base+1], e201);
    end

    // Valid pulsed while busy is ignored
    run_frame(10'(200), e200, "busy_ign", 1'b1);

    // Asynchronous reset after the 7th SCLK rise
    @(negedge clock);
    sample_in = 10'd200;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    n = 0;
    while (!(mon_bits >= 7 && !dac_cs_n) && n < 200) begin @(negedge clock); n++; end
    chk("mid_reached7", (mon_bits >= 7) ? 1 : 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_cs_n",  dac_cs_n, 1);
    chk("mid_sclk",  dac_sclk, 0);
    chk("mid_ldac",  dac_ldac_n, 1);
    chk("mid_ready", sample_ready, 1);
    chk("mid_busy",  busy, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    run_frame(10'(200), e200, "post_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/fir_dac_tx.md
Name: fir_dac_tx

Overview:
- Output-side companion to the FIR filter: takes each filtered parallel sample and serializes it to an external 10-bit SPI DAC (MCP49x1-style 16-bit write frame), then pulses LDAC to update the analog output.
- Sits between the fir data_out/sample strobe and the board DAC pins.
- Single clock domain; SPI clock derived internally by an integer divider.

Parameters:
- WIDTH, 10, sample width in bits; legal range 1..12.
- CLK_DIV, 4, system clocks per SCLK half-period; minimum 1.
- CONFIG, 4'b0111, 4 DAC config bits sent first (ch A, buffered, 1x gain, active).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_in  input  WIDTH  sample to convert.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  high only in IDLE; a transfer occurs on a rising edge with valid && ready.
- dac_cs_n  output  1  SPI chip select, active low.
- dac_sclk  output  1  SPI clock, idle low (mode 0).
- dac_mosi  output  1  SPI data, MSB first.
- dac_ldac_n  output  1  DAC latch strobe, active low.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: sample_ready=1, dac_cs_n=1, dac_sclk=0, dac_mosi=0, dac_ldac_n=1, busy=0, state=IDLE.
- Reset mid-frame aborts immediately (asynchronously) to these values; no partial frame resumes.
- Frame, 16 bits: {CONFIG[3:0], sample_in[WIDTH-1:0], (12-WIDTH) zeros}. It is latched into a shift register on acceptance; later changes to sample_in do not affect it.
- States:
  - IDLE: ready=1. On valid, latch frame, go to SHIFT.
  - SHIFT: cs_n=0. Low and high SCLK phases each last CLK_DIV clocks. 16 low+high pairs = 32*CLK_DIV clocks.
    - mosi shows frame bit 15 on SHIFT entry.
    - Each subsequent falling SCLK edge advances to the next bit.
    - DAC samples mosi on the rising edge.
    - After the 16th high phase, sclk returns low and state goes to GAP.
  - GAP: cs_n=1, sclk=0, CLK_DIV clocks. Then go to LDAC.
  - LDAC: ldac_n=0 for CLK_DIV clocks. Then go to IDLE.
- Timing:
  - sample_ready is low for exactly 34*CLK_DIV clocks per frame.
  - With valid held high, consecutive acceptances are 34*CLK_DIV+1 clocks apart (one IDLE cycle).
- Counters:
  - Divider counter 0..CLK_DIV-1.
  - Bit counter 0..15, wraps to 0 only on leaving SHIFT.
  - Size the divider counter with $clog2(CLK_DIV+1).
- sample_valid outside IDLE is ignored; no buffering, no overflow flag.
- sclk, cs_n, mosi and ldac_n are driven directly from flops (glitch-free).

Optional Feature:
- Macro FIR_DAC_SIGNED_EN.
- Defined: sample_in is two's complement. Invert its MSB before framing (offset binary), so -2^(WIDTH-1) maps to DAC code 0 and 0 maps to mid-scale.
- Undefined: sample_in is unsigned and passes unchanged.

Test Plan:
- Basic frame (CLK_DIV=4, unsigned): reset, sample_in=10'd200, one-cycle valid. Expect:
  - 16 bits captured on sclk rises = 16'h7320.
  - cs_n low for 128 clocks; ldac_n low for 4 clocks after a 4-clock cs_n-high gap.
  - ready low 136 clocks.
- Extremes, unsigned: 10'd0 -> 16'h7000; 10'h3FF -> 16'h7FFC.
- Signed (FIR_DAC_SIGNED_EN defined): 10'h3FF (-1) -> 16'h77FC; 10'h200 -> 16'h7000; 10'h000 -> 16'h7800.
- Back-to-back: valid held high with 200 then 201. Expect:
  - Acceptances exactly 137 clocks apart.
  - Frames 16'h7320, then 16'h7324.
  - sample_in changes during frame 1 do not corrupt it.
- Busy ignore: pulse valid with 10'd5 during SHIFT of the 200 frame. Expect no second frame and ready timing unchanged.
- Reset mid-frame: assert reset after the 7th sclk rise. Expect:
  - cs_n=1, sclk=0, ldac_n=1, ready=1 in the same cycle (async).
  - After release, a new 10'd200 sends a full clean 16'h7320.
